// File: rtl/hist_feed_arbiter.sv
// Round-robin feeder for the distinct-value history tracker.
// Holds each grant on the tracker input and sequences tracker reset.
module hist_feed_arbiter #(
  parameter int DATA_W      = 8,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      flush_in,
  input  logic [N_REQ-1:0]          req_in,
  input  logic [N_REQ*DATA_W-1:0]   req_data_in,
  output logic [N_REQ-1:0]          ack_out,
  output logic [DATA_W-1:0]         hist_data_out,
  output logic                      hist_reset_out,
  output logic                      hist_busy_out,
  output logic [$clog2(N_REQ)-1:0]  grant_idx_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES);

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_WARM  = 2'd1;
  localparam logic [1:0] ST_ARB   = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     pick_nx;
  logic [DATA_W-1:0] pick_data;
  logic [CW-1:0]     cnt;
  logic              found;

  // Two passes: indices at/after the pointer first, then the wrap-around.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_in[k] && IW'(k) >= rr_ptr) begin
        found     = 1'b1;
        pick      = IW'(k);
        pick_data = req_data_in[k*DATA_W +: DATA_W];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_in[k]) begin
        found     = 1'b1;
        pick      = IW'(k);
        pick_data = req_data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  assign pick_nx = (pick == IW'(N_REQ-1)) ? '0 : pick + IW'(1);

  always_comb begin
    state_nx = state;
    case (state)
      ST_FLUSH: state_nx = ST_WARM;
      ST_WARM:  state_nx = ST_ARB;
      ST_ARB:   if (found) state_nx = ST_HOLD;
      ST_HOLD:  if (cnt == '0) state_nx = ST_ARB;
      default:  state_nx = ST_FLUSH;
    endcase
    if (flush_in) state_nx = ST_FLUSH;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state          <= ST_FLUSH;
      rr_ptr         <= '0;
      cnt            <= '0;
      ack_out        <= '0;
      hist_data_out  <= '0;
      hist_reset_out <= 1'b1;
      hist_busy_out  <= 1'b1;
      grant_idx_out  <= '0;
    end else begin
      state          <= state_nx;
      ack_out        <= '0;
      hist_reset_out <= (state_nx == ST_FLUSH);
      hist_busy_out  <= (state_nx != ST_ARB);
      if (state_nx == ST_FLUSH) begin
        hist_data_out <= '0;
      end else if (state == ST_ARB) begin
        if (found) begin
          grant_idx_out <= pick;
          hist_data_out <= pick_data;
          rr_ptr        <= pick_nx;
          cnt           <= CW'(HOLD_CYCLES-1);
        end
      end else if (state == ST_HOLD) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        // Registered ack lands on the cycle the counter reads zero.
        if (cnt == CW'(1)) ack_out <= N_REQ'(1) << grant_idx_out;
      end
    end
  end

endmodule

// File: tb/tb_hist_feed_arbiter.sv
// Self-checking bench for hist_feed_arbiter.
// Directed scenarios plus a randomized run against a transaction model.
module tb_hist_feed_arbiter;

  localparam int H = 3;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [3:0]  req_in = '0;
  logic [31:0] req_data_in = '0;
  logic [3:0]  ack_out;
  logic [7:0]  hist_data_out;
  logic        hist_reset_out;
  logic        hist_busy_out;
  logic [1:0]  grant_idx_out;

  logic        rst3 = 1'b1;
  logic        flush3 = 1'b0;
  logic [2:0]  req3 = '0;
  logic [23:0] data3 = '0;
  logic [2:0]  ack3;
  logic [7:0]  hd3;
  logic        hr3;
  logic        hb3;
  logic [1:0]  gi3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  hist_feed_arbiter #(.DATA_W(8), .N_REQ(4), .HOLD_CYCLES(H)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .flush_in(flush_in),
    .req_in(req_in), .req_data_in(req_data_in), .ack_out(ack_out),
    .hist_data_out(hist_data_out), .hist_reset_out(hist_reset_out),
    .hist_busy_out(hist_busy_out), .grant_idx_out(grant_idx_out)
  );

  hist_feed_arbiter #(.DATA_W(8), .N_REQ(3), .HOLD_CYCLES(H)) dut3 (
    .clk_in(clk_in), .reset_in(rst3), .flush_in(flush3),
    .req_in(req3), .req_data_in(data3), .ack_out(ack3),
    .hist_data_out(hd3), .hist_reset_out(hr3),
    .hist_busy_out(hb3), .grant_idx_out(gi3)
  );

  task automatic do_reset;
    req_in = '0;
    flush_in = 1'b0;
    @(negedge clk_in) reset_in = 1'b1;
    @(negedge clk_in) reset_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset;
    #2 reset_in = 1'b1;
    #1;
    n_cmp++;
    if ({ack_out, hist_data_out, hist_reset_out, hist_busy_out, grant_idx_out}
        !== {4'h0, 8'h00, 1'b1, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_vals got ack=%h d=%h r=%b b=%b g=%0d",
               ack_out, hist_data_out, hist_reset_out, hist_busy_out,
               grant_idx_out);
    end
    @(negedge clk_in) reset_in = 1'b0;
    #1;
    n_cmp++;
    if (hist_reset_out !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hold got %b want 1", hist_reset_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if ({hist_reset_out, hist_busy_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL warm got r=%b b=%b want r=0 b=1",
               hist_reset_out, hist_busy_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (hist_busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL arb_idle got busy=%b want 0", hist_busy_out);
    end
  endtask

  task automatic test_single;
    req_in = 4'b0010;
    req_data_in[15:8] = 8'h5A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      if (k <= 3) begin
        n_cmp++;
        if (hist_data_out !== 8'h5A || hist_busy_out !== 1'b1) begin
          n_bad++;
          $display("FAIL single_hold c%0d got d=%h b=%b want 5a/1",
                   k, hist_data_out, hist_busy_out);
        end
      end
      n_cmp++;
      if (ack_out !== ((k == 3) ? 4'b0010 : 4'b0000)) begin
        n_bad++;
        $display("FAIL single_ack c%0d got %b", k, ack_out);
      end
      if (k == 3) req_in = '0;
    end
    n_cmp++;
    if ({grant_idx_out, hist_busy_out, hist_data_out} !== {2'd1, 1'b0, 8'h5A}) begin
      n_bad++;
      $display("FAIL single_end got g=%0d b=%b d=%h want 1/0/5a",
               grant_idx_out, hist_busy_out, hist_data_out);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] seen;
    do_reset();
    req_data_in = 32'h40302010;
    req_in = 4'hF;
    seen = '0;
    for (int g = 0; g < 5; g++) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk_in);
        if (k == 1) begin
          n_cmp++;
          if (grant_idx_out !== 2'(g % 4) ||
              hist_data_out !== 8'((g % 4 + 1) * 16)) begin
            n_bad++;
            $display("FAIL rr_grant g%0d got idx=%0d d=%h want %0d",
                     g, grant_idx_out, hist_data_out, g % 4);
          end
        end
        if (k == 3 && g < 4) seen = seen | ack_out;
        n_cmp++;
        if (ack_out !== ((k == 3) ? 4'(1) << (g % 4) : 4'b0)) begin
          n_bad++;
          $display("FAIL rr_ack g%0d c%0d got %b", g, k, ack_out);
        end
        if (k == 4) begin
          n_cmp++;
          if (hist_busy_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_gap g%0d got busy=%b want 0", g, hist_busy_out);
          end
        end
      end
    end
    req_in = '0;
    n_cmp++;
    if (seen !== 4'hF) begin
      n_bad++;
      $display("FAIL rr_round got acks=%b want 1111", seen);
    end
  endtask

  task automatic test_flush;
    logic [3:0] acks;
    acks = '0;
    req_in = 4'b0100;
    req_data_in[23:16] = 8'h77;
    @(negedge clk_in);
    n_cmp++;
    if (hist_data_out !== 8'h77 || grant_idx_out !== 2'd2) begin
      n_bad++;
      $display("FAIL flush_grant got d=%h g=%0d want 77/2",
               hist_data_out, grant_idx_out);
    end
    @(negedge clk_in);
    acks = acks | ack_out;
    flush_in = 1'b1;
    @(negedge clk_in);
    acks = acks | ack_out;
    flush_in = 1'b0;
    n_cmp++;
    if ({hist_reset_out, hist_data_out} !== {1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL flush_rst got r=%b d=%h want 1/00",
               hist_reset_out, hist_data_out);
    end
    @(negedge clk_in);
    acks = acks | ack_out;
    n_cmp++;
    if ({hist_reset_out, hist_busy_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_warm got r=%b b=%b want 0/1",
               hist_reset_out, hist_busy_out);
    end
    @(negedge clk_in);
    acks = acks | ack_out;
    n_cmp++;
    if (acks !== 4'b0 || hist_busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_noack got acks=%b busy=%b want 0/0",
               acks, hist_busy_out);
    end
    @(negedge clk_in);
    n_cmp++;
    if (hist_data_out !== 8'h77 || grant_idx_out !== 2'd2) begin
      n_bad++;
      $display("FAIL flush_regrant got d=%h g=%0d want 77/2",
               hist_data_out, grant_idx_out);
    end
    req_in[0] = 1'b1;
    req_in[3] = 1'b1;
    req_data_in[7:0] = 8'h11;
    req_data_in[31:24] = 8'h33;
    @(negedge clk_in);
    @(negedge clk_in);
    n_cmp++;
    if (ack_out !== 4'b0100) begin
      n_bad++;
      $display("FAIL flush_ack2 got %b want 0100", ack_out);
    end
    req_in[2] = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    n_cmp++;
    if (grant_idx_out !== 2'd3 || hist_data_out !== 8'h33) begin
      n_bad++;
      $display("FAIL flush_ptr got g=%0d d=%h want 3/33",
               grant_idx_out, hist_data_out);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    req_in = '0;
    @(negedge clk_in);
  endtask

  task automatic test_reset_mid;
    req_in = 4'b0100;
    req_data_in[23:16] = 8'h55;
    @(negedge clk_in);
    #2 reset_in = 1'b1;
    #1;
    n_cmp++;
    if ({ack_out, hist_data_out, hist_reset_out, hist_busy_out, grant_idx_out}
        !== {4'h0, 8'h00, 1'b1, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL midreset got ack=%h d=%h r=%b b=%b g=%0d",
               ack_out, hist_data_out, hist_reset_out, hist_busy_out,
               grant_idx_out);
    end
    @(negedge clk_in) reset_in = 1'b0;
    req_in = 4'hF;
    req_data_in = 32'hD0C0B0A0;
    #1;
    n_cmp++;
    if (hist_reset_out !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_rel got r=%b want 1", hist_reset_out);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    n_cmp++;
    if (grant_idx_out !== 2'd0 || hist_data_out !== 8'hA0) begin
      n_bad++;
      $display("FAIL midreset_first got g=%0d d=%h want 0/a0",
               grant_idx_out, hist_data_out);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    req_in = '0;
    @(negedge clk_in);
  endtask

  task automatic test_tracker;
    logic [7:0] vals [4];
    logic [7:0] trk [$];
    logic       got;
    vals = '{8'h01, 8'h02, 8'h01, 8'h03};
    for (int n = 0; n < 4; n++) begin
      req_in[1] = 1'b1;
      req_data_in[15:8] = vals[n];
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk_in);
        if (ack_out[1]) begin
          got = 1'b1;
          for (int q = trk.size() - 1; q >= 0; q--)
            if (trk[q] == hist_data_out) trk.delete(q);
          trk.push_front(hist_data_out);
          if (trk.size() > 4) void'(trk.pop_back());
        end
      end
      n_cmp++;
      if (!got) begin
        n_bad++;
        $display("FAIL trk_timeout value %0d got no ack want ack", n);
      end
      req_in = '0;
      @(negedge clk_in);
    end
    n_cmp++;
    if (trk.size() != 3 || trk[0] !== 8'h03 || trk[1] !== 8'h01 ||
        trk[2] !== 8'h02) begin
      n_bad++;
      $display("FAIL trk_list got size %0d want 03 01 02", trk.size());
    end
    repeat (5) @(negedge clk_in);
    n_cmp++;
    if (hist_data_out !== 8'h03 || hist_busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL trk_idle got d=%h b=%b want 03/0",
               hist_data_out, hist_busy_out);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk_in) rst3 = 1'b1;
    @(negedge clk_in) rst3 = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    data3 = 24'h0C0B0A;
    req3 = 3'b111;
    for (int g = 0; g < 4; g++) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk_in);
        n_cmp++;
        if (gi3 > 2'd2) begin
          n_bad++;
          $display("FAIL wrap_range got idx=%0d want <3", gi3);
        end
        if (k == 1) begin
          n_cmp++;
          if (gi3 !== 2'(g % 3) || hd3 !== 8'(8'h0A + g % 3)) begin
            n_bad++;
            $display("FAIL wrap_grant g%0d got idx=%0d d=%h want %0d",
                     g, gi3, hd3, g % 3);
          end
        end
        if (k == 3) begin
          n_cmp++;
          if (ack3 !== 3'(1) << (g % 3)) begin
            n_bad++;
            $display("FAIL wrap_ack g%0d got %b", g, ack3);
          end
        end
      end
    end
    req3 = '0;
  endtask

  task automatic test_random;
    int         m_left;
    int         m_fl;
    int         m_ptr;
    int         m_idx;
    logic [7:0] m_data;
    logic [3:0] e_ack;
    int         j;
    do_reset();
    m_left = 0;
    m_fl = 0;
    m_ptr = 0;
    m_idx = 0;
    m_data = 8'h00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      e_ack = (m_left == 1 && m_fl == 0) ? 4'(1) << m_idx : 4'b0;
      n_cmp++;
      if (ack_out !== e_ack || hist_data_out !== m_data ||
          grant_idx_out !== 2'(m_idx) ||
          hist_busy_out !== (m_left > 0 || m_fl > 0) ||
          hist_reset_out !== (m_fl == 2)) begin
        n_bad++;
        $display("FAIL rand c%0d got a=%b d=%h g=%0d b=%b r=%b want a=%b d=%h g=%0d",
                 cyc, ack_out, hist_data_out, grant_idx_out, hist_busy_out,
                 hist_reset_out, e_ack, m_data, m_idx);
      end
      for (int i = 0; i < 4; i++) begin
        if (req_in[i] && e_ack[i]) begin
          req_in[i] = 1'($urandom_range(0, 1));
          req_data_in[i*8 +: 8] = 8'($urandom);
        end else if (!req_in[i] && $urandom_range(0, 3) == 0) begin
          req_in[i] = 1'b1;
          req_data_in[i*8 +: 8] = 8'($urandom);
        end
      end
      flush_in = ($urandom_range(0, 39) == 0);
      if (flush_in) begin
        m_fl = 2;
        m_left = 0;
        m_data = 8'h00;
      end else if (m_fl > 0) begin
        m_fl--;
      end else if (m_left > 0) begin
        m_left--;
      end else if (req_in != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (m_left == 0 && req_in[j]) begin
            m_idx = j;
            m_data = req_data_in[j*8 +: 8];
            m_ptr = (j + 1) % 4;
            m_left = H;
          end
        end
      end
      @(negedge clk_in);
    end
    flush_in = 1'b0;
    req_in = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_reset_mid();
    test_tracker();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hist_feed_arbiter.md
# hist_feed_arbiter

Round-robin arbiter and sequencer that shares the single `data_in` port of the distinct-value history tracker (four-deep most-recent-distinct list with `out_0..out_3` / `out_valid_0..3`) between `N_REQ` requesters. Each granted value is held stable on the tracker input for `HOLD_CYCLES` clocks so the tracker's state machine fully absorbs it. The block also sequences the tracker's synchronous reset on flush, including its one-cycle idle warm-up. It sits directly in front of the tracker; `hist_data_out` drives tracker `data_in`, and `hist_reset_out` drives tracker `reset_in`.

## Interface
- `DATA_W`, 8, width of each value.
- `N_REQ`, 4, number of requesters, 2..16.
- `HOLD_CYCLES`, 3, cycles each granted value is held, minimum 2.
- `clk_in`  in  1  single clock, rising edge.
- `reset_in`  in  1  reset; one clock, reset is asynchronous and active-high.
- `flush_in`  in  1  single-cycle pulse; aborts the current transfer and resets the tracker.
- `req_in`  in  N_REQ  per-requester level request; data must stay stable while high and un-acked.
- `req_data_in`  in  N_REQ*DATA_W  requester i's value in bits [i*DATA_W +: DATA_W].
- `ack_out`  out  N_REQ  one-cycle pulse; the value of requester i has been delivered.
- `hist_data_out`  out  DATA_W  to tracker `data_in`.
- `hist_reset_out`  out  1  to tracker `reset_in` (synchronous, active-high at tracker).
- `hist_busy_out`  out  1  high in every state except ST_ARB.
- `grant_idx_out`  out  $clog2(N_REQ)  index of the last granted requester.

## Operation
- All outputs are registered.
- **Reset values:**
  - `ack_out` = 0, `hist_data_out` = 0, `hist_reset_out` = 1, `hist_busy_out` = 1, `grant_idx_out` = 0.
  - Internal: round-robin pointer `rr_ptr` = 0, hold counter = 0, state = ST_FLUSH.
- **States:**
  - **ST_FLUSH:** `hist_reset_out` = 1, `hist_data_out` = 0. Next state is ST_WARM.
  - **ST_WARM:** `hist_reset_out` = 0. Covers the tracker's idle cycle. Next state is ST_ARB.
  - **ST_ARB:** `hist_busy_out` = 0.
    - If any `req_in` bit is set, pick the first set index searching `rr_ptr`, `rr_ptr+1`, … modulo `N_REQ`.
    - Latch that index into `grant_idx_out` and its data into `hist_data_out`.
    - Set `rr_ptr` = index+1 modulo `N_REQ`, and the counter = `HOLD_CYCLES`-1.
    - Go to ST_HOLD. With no request, stay in ST_ARB.
  - **ST_HOLD:** `hist_data_out` is held.
    - While the counter is nonzero, decrement it.
    - When the counter reaches 0, go to ST_ARB.
    - `ack_out[grant_idx_out]` = 1 during the final ST_HOLD cycle, i.e. the cycle in which the counter reads 0.
- **Flush:** `flush_in` in any state forces ST_FLUSH on the next edge.
  - Flush takes priority over requests and over hold completion.
  - An aborted transfer is never acked; the requester keeps `req_in` high and is re-arbitrated.
  - `rr_ptr` is preserved across flush.
- **Idle hold:** `hist_data_out` keeps the last granted value in ST_ARB, so the tracker sees no spurious change.
- **Duplicates:** values equal to the current `hist_data_out` are still granted, held and acked normally. Duplicate filtering is the tracker's job.
- **Index width:** `grant_idx_out` and `rr_ptr` wrap from `N_REQ`-1 to 0. When `N_REQ` is not a power of two, the wrap is explicit, not by overflow.

## Timing
- **Grant latency:** request seen in ST_ARB at cycle t gives `hist_data_out` updated at t+1.
  - The value is stable on cycles t+1 .. t+`HOLD_CYCLES`.
  - `ack_out` is high on cycle t+`HOLD_CYCLES`.
  - Back in ST_ARB at t+`HOLD_CYCLES`+1.
- **Throughput:** one value per `HOLD_CYCLES`+1 cycles under continuous requests.
- **Requester rule:** after seeing `ack_out` high, the requester must drop `req_in` or present new data by the next cycle.
  - A still-high `req_in` at the next ST_ARB cycle is a new request.
- **Flush sequencing:** `flush_in` at cycle t gives `hist_reset_out` high at t+1, low at t+2, and ST_ARB at t+3.
- **Reset release:** after `reset_in` falls, the first edge enters ST_WARM and the second enters ST_ARB.
  - `hist_reset_out` stays high from reset assertion until the first edge after release.
- **Reset mid-transfer:** asynchronous.
  - All outputs take their reset values immediately.
  - No ack is issued for the transfer in flight.

## Test plan
- **Single request** (N_REQ=4, HOLD_CYCLES=3): `req_in`=0010 with data 0x5A, after ST_ARB is reached.
  - `hist_data_out`=0x5A for 3 cycles.
  - `ack_out`=0010 on the 3rd cycle.
  - `grant_idx_out`=1, `hist_busy_out` low again the next cycle.
- **Round-robin fairness:** all four requesters held high with data 0x10, 0x20, 0x30, 0x40.
  - Grant order is 0, 1, 2, 3, 0, with one grant every 4 cycles.
  - Each `ack_out` bit pulses once per round.
- **Flush mid-hold:** grant requester 2 (0x77), then pulse `flush_in` on the 2nd hold cycle.
  - No ack is issued.
  - `hist_reset_out` is high for exactly 1 cycle and `hist_data_out`=0.
  - Requester 2 is re-granted 3 cycles after the flush, and `rr_ptr` continues from 3.
- **Reset behaviour:** assert `reset_in` asynchronously mid-hold.
  - Outputs go to reset values without a clock edge.
  - After release: `hist_reset_out` is high for the first cycle, and the first grant goes to requester 0.
- **End-to-end with tracker:** requests deliver 0x01, 0x02, 0x01, 0x03.
  - Tracker ends with out_0..2 = 0x03, 0x01, 0x02.
  - `hist_data_out` stays at 0x03 while idle.
- **Wrap with N_REQ=3:** all requesters high.
  - Grant sequence is 0, 1, 2, 0.
  - `grant_idx_out` never reads 3.
